// File: rtl/text_screen_buffer.sv
// Character grid behind the character-feeder link: positioned writes, scroll-up and clear
// sweeps (one cell per clock), a one-deep pending slot for requests that arrive mid-sweep.
module text_screen_buffer #(
    parameter int ROW_NUMBER  = 15,
    parameter int COL_NUMBER  = 40,
    parameter int ROW_BIT_LEN = 4,
    parameter int COL_BIT_LEN = 6,
    parameter int CHAR_ID_LEN = 8,
    parameter logic [CHAR_ID_LEN-1:0] BLANK_CHAR = CHAR_ID_LEN'(8'h20)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    input  logic [ROW_BIT_LEN-1:0] wr_row,
    input  logic [COL_BIT_LEN-1:0] wr_col,
    input  logic [CHAR_ID_LEN-1:0] wr_char,
    input  logic                   push_up,
    input  logic                   reset_call,
    input  logic [ROW_BIT_LEN-1:0] rd_row,
    input  logic [COL_BIT_LEN-1:0] rd_col,
    output logic [CHAR_ID_LEN-1:0] rd_char,
    output logic                   busy,
    output logic                   overflow,
    output logic [1:0]             sweep_state
);
    // Handshake: wr_valid and reset_call are one-cycle strobes with no ready. The buffer always
    // takes them: applied at once when idle, parked in the pending slot, or dropped with overflow.

    localparam int CELLS  = ROW_NUMBER * COL_NUMBER;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int RW1    = ROW_BIT_LEN + 1;
    localparam int CW1    = COL_BIT_LEN + 1;
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COL_NUMBER);
    localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(CELLS - COL_NUMBER - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [RW1-1:0]    ROWS_L    = RW1'(ROW_NUMBER);
    localparam logic [CW1-1:0]    COLS_L    = CW1'(COL_NUMBER);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SCROLL_COPY = 2'd1,
        SCROLL_FILL = 2'd2,
        CLEAR       = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        p;
    logic [CHAR_ID_LEN-1:0]   mem [CELLS];

    logic                     pend_valid, pend_reset, pend_push;
    logic [ROW_BIT_LEN-1:0]   pend_row;
    logic [COL_BIT_LEN-1:0]   pend_col;
    logic [CHAR_ID_LEN-1:0]   pend_char;

    logic                     ev_reset, ev_wr, ev_push, ev_ok, rd_ok, slot_full;
    logic [ROW_BIT_LEN-1:0]   ev_row;
    logic [COL_BIT_LEN-1:0]   ev_col;
    logic [CHAR_ID_LEN-1:0]   ev_char;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr, rd_addr;
    logic [CHAR_ID_LEN-1:0]   mem_data;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_BIT_LEN-1:0] r,
                                                  input logic [COL_BIT_LEN-1:0] c);
        return ADDR_W'(r) * COLS_A + ADDR_W'(c);
    endfunction

    function automatic logic in_range(input logic [ROW_BIT_LEN-1:0] r,
                                      input logic [COL_BIT_LEN-1:0] c);
        return ({1'b0, r} < ROWS_L) && ({1'b0, c} < COLS_L);
    endfunction

    assign sweep_state = state;

    // An idle cycle serves the pending slot first; live inputs only when it is empty.
    always_comb begin
        ev_reset  = pend_valid ? pend_reset : reset_call;
        ev_wr     = pend_valid ? !pend_reset : wr_valid;
        ev_push   = pend_valid ? pend_push : push_up;
        ev_row    = pend_valid ? pend_row : wr_row;
        ev_col    = pend_valid ? pend_col : wr_col;
        ev_char   = pend_valid ? pend_char : wr_char;
        ev_ok     = in_range(ev_row, ev_col);
        rd_ok     = in_range(rd_row, rd_col);
        rd_addr   = addr_of(rd_row, rd_col);
        slot_full = pend_valid && (state != IDLE);
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = p;
        mem_data = BLANK_CHAR;
        case (state)
            SCROLL_COPY: begin
                mem_we   = 1'b1;
                mem_data = mem[p + COLS_A];
            end
            SCROLL_FILL, CLEAR: mem_we = 1'b1;
            IDLE: begin
                if (!ev_reset && ev_wr && ev_ok) begin
                    mem_we   = 1'b1;
                    mem_addr = addr_of(ev_row, ev_col);
                    mem_data = ev_char;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            p          <= '0;
            busy       <= 1'b1;
            pend_valid <= 1'b0;
            pend_reset <= 1'b0;
            pend_push  <= 1'b0;
            pend_row   <= '0;
            pend_col   <= '0;
            pend_char  <= '0;
            overflow   <= 1'b0;
            rd_char    <= '0;
        end else begin
            rd_char <= rd_ok ? mem[rd_addr] : BLANK_CHAR;

            case (state)
                IDLE: begin
                    p <= '0;
                    if (ev_reset) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end else if (ev_wr && ev_push) begin
                        state <= SCROLL_COPY;
                        busy  <= 1'b1;
                    end
                end
                SCROLL_COPY: begin
                    p <= p + 1'b1;
                    if (p == LAST_COPY) state <= SCROLL_FILL;
                end
                SCROLL_FILL, CLEAR: begin
                    if (p == LAST_CELL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        p     <= '0;
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase

            // The slot takes live events while sweeping, or refills in the cycle it is consumed.
            if (state != IDLE || pend_valid) begin
                if (reset_call) begin
                    pend_valid <= 1'b1;
                    pend_reset <= 1'b1;
                    pend_push  <= 1'b0;
                    pend_row   <= wr_row;
                    pend_col   <= wr_col;
                    pend_char  <= wr_char;
                    if (slot_full && !pend_reset) overflow <= 1'b1;
                end else if (wr_valid) begin
                    if (slot_full) begin
                        overflow <= 1'b1;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_reset <= 1'b0;
                        pend_push  <= push_up;
                        pend_row   <= wr_row;
                        pend_col   <= wr_col;
                        pend_char  <= wr_char;
                    end
                end else if (state == IDLE) begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_text_screen_buffer.sv
// Directed bench for text_screen_buffer: reads push expectations to a queue, a negedge
// monitor pops and compares rd_char; busy/overflow are checked directly by the driver.
module tb_text_screen_buffer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_row = '0;
    logic [5:0] wr_col = '0;
    logic [7:0] wr_char = '0;
    logic       push_up = 1'b0;
    logic       reset_call = 1'b0;
    logic [3:0] rd_row = '0;
    logic [5:0] rd_col = '0;
    logic [7:0] rd_char;
    logic       busy;
    logic       overflow;
    logic [1:0] sweep_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       rd_req = 1'b0;
    logic       rd_req_d = 1'b0;

    text_screen_buffer dut (
        .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_row(wr_row),
        .wr_col(wr_col), .wr_char(wr_char), .push_up(push_up), .reset_call(reset_call),
        .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char), .busy(busy),
        .overflow(overflow), .sweep_state(sweep_state)
    );

    // ---- clock / watchdog ----
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---- read-response monitor / scoreboard ----
    always @(posedge clock) rd_req_d <= rd_req;

    always @(negedge clock) begin
        logic [7:0] e;
        string      n;
        if (rd_req_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %02h, no expectation queued", rd_char);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rd_char !== e) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h", n, rd_char, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---- driver tasks (enter and leave on a negedge) ----
    task automatic drive(input logic [3:0] r, input logic [5:0] c, input logic [7:0] ch,
                         input logic push, input logic clr);
        wr_valid   = 1'b1;
        wr_row     = r;
        wr_col     = c;
        wr_char    = ch;
        push_up    = push;
        reset_call = clr;
        @(negedge clock);
        wr_valid   = 1'b0;
        push_up    = 1'b0;
        reset_call = 1'b0;
    endtask

    task automatic read(input string name, input logic [3:0] r, input logic [5:0] c,
                        input logic [7:0] exp);
        rd_row = r;
        rd_col = c;
        rd_req = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    task automatic measure_busy(input string name, input int exp_len);
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check(name, n, exp_len);
    endtask

    // ---- directed stimulus ----
    initial begin
        repeat (3) @(negedge clock);
        check("reset_rd_char", rd_char, 8'h00);
        check("reset_busy_level", busy, 1);
        check("reset_overflow", overflow, 0);
        check("reset_state_clear", sweep_state, 2'd3);
        reset_n = 1'b1;
        measure_busy("reset_busy_len", 600);
        check("idle_state", sweep_state, 2'd0);
        read("blank_0_0", 4'd0, 6'd0, 8'h20);
        read("blank_14_39", 4'd14, 6'd39, 8'h20);

        // single write and neighbour
        drive(4'd3, 6'd7, 8'h41, 1'b0, 1'b0);
        read("wr_3_7", 4'd3, 6'd7, 8'h41);
        read("nb_3_8", 4'd3, 6'd8, 8'h20);

        // fill row r with 30+r, then scroll with a write at (14,39)
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                drive(4'(r), 6'(c), 8'(8'h30 + r), 1'b0, 1'b0);
        drive(4'd14, 6'd39, 8'h5A, 1'b1, 1'b0);
        check("scroll_busy_start", busy, 1);
        drive(4'd14, 6'd0, 8'h42, 1'b0, 1'b0);
        // one of the 600 busy cycles was spent issuing the queued write
        measure_busy("scroll_busy_len", 599);
        for (int c = 0; c < 40; c++) read("scroll_row0", 4'd0, 6'(c), 8'h31);
        check("pending_write_no_scroll", busy, 0);
        read("scroll_13_39", 4'd13, 6'd39, 8'h5A);
        read("scroll_13_0", 4'd13, 6'd0, 8'h3E);
        read("scroll_7_5", 4'd7, 6'd5, 8'h38);
        read("pending_14_0", 4'd14, 6'd0, 8'h42);
        for (int c = 1; c < 40; c++) read("scroll_row14", 4'd14, 6'(c), 8'h20);
        check("overflow_after_pending", overflow, 0);

        // clear wins over a simultaneous write
        drive(4'd0, 6'd0, 8'h41, 1'b0, 1'b1);
        check("clear_busy_start", busy, 1);
        measure_busy("clear_busy_len", 600);
        read("clear_0_0", 4'd0, 6'd0, 8'h20);
        read("clear_13_39", 4'd13, 6'd39, 8'h20);
        read("clear_14_0", 4'd14, 6'd0, 8'h20);
        check("clear_no_overflow", overflow, 0);

        // two writes during one sweep: first queued, second dropped
        drive(4'd3, 6'd3, 8'h77, 1'b0, 1'b0);
        drive(4'd0, 6'd0, 8'h11, 1'b1, 1'b0);
        drive(4'd1, 6'd1, 8'h22, 1'b0, 1'b0);
        drive(4'd2, 6'd2, 8'h33, 1'b0, 1'b0);
        check("overflow_set", overflow, 1);
        measure_busy("scroll2_busy_len", 598);
        @(negedge clock);
        check("scroll2_idle_after_pending", busy, 0);
        read("queued_1_1", 4'd1, 6'd1, 8'h22);
        read("dropped_2_2", 4'd2, 6'd2, 8'h20);
        read("scroll2_2_3", 4'd2, 6'd3, 8'h77);
        read("scroll2_3_3", 4'd3, 6'd3, 8'h20);
        read("scroll2_0_0", 4'd0, 6'd0, 8'h20);
        check("overflow_sticky", overflow, 1);

        // out-of-range writes change nothing; (0,40) would alias (1,0)
        drive(4'd15, 6'd0, 8'h66, 1'b0, 1'b0);
        drive(4'd0, 6'd40, 8'h67, 1'b0, 1'b0);
        check("oor_no_busy", busy, 0);
        read("oor_15_0", 4'd15, 6'd0, 8'h20);
        read("oor_alias_1_0", 4'd1, 6'd0, 8'h20);
        read("oor_0_40", 4'd0, 6'd40, 8'h20);

        // reset in the middle of a scroll
        drive(4'd14, 6'd39, 8'h5A, 1'b1, 1'b0);
        repeat (300) @(negedge clock);
        check("mid_scroll_busy", busy, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_state_clear", sweep_state, 2'd3);
        check("abort_overflow_cleared", overflow, 0);
        @(negedge clock);
        reset_n = 1'b1;
        measure_busy("abort_busy_len", 600);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                read("after_abort_blank", 4'(r), 6'(c), 8'h20);

        repeat (3) @(negedge clock);
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
